ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset).
- Sits beside the keyboard receive path on the same keyClock/keyData lines.
- Drives the lines open-drain through active-high pull-low enables.
- Asserts busy for the whole transaction so the receive path ignores line activity it causes.

---
 rtl/ps2_host_tx.sv | 277 +++++++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
//
// Sends one command byte (e.g. 0xED set LEDs, 0xF4 enable, 0xFF reset) to a PS/2
// device over the shared keyClock/keyData lines. The lines are driven open-drain
// through active-high pull-low enables. busy covers the whole transaction so the
// neighbouring receive path can ignore the line activity caused by this block.
//
// Transaction: inhibit clock low -> start bit -> 8 data bits LSB first -> odd
// parity -> stop (release) -> sample device ack -> wait for idle lines -> done.
//
// Ports:
//   sysclk        in   system clock (50 MHz)
//   rst_n         in   asynchronous active-low reset
//   tx_valid      in   request to send tx_data
//   tx_data[7:0]  in   command byte
//   tx_ready      out  idle; request accepted on tx_valid && tx_ready
//   keyClock      in   PS/2 clock line level
//   keyData       in   PS/2 data line level
//   keyClockDrive out  1 = pull clock line low
//   keyDataDrive  out  1 = pull data line low
//   busy          out  transaction in progress
//   done          out  one-cycle pulse at transaction end
//   ack_err       out  with done: device did not acknowledge (held until next accept)
//   timeout_err   out  with done: transaction timed out (held until next accept)

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000,
    parameter int unsigned FILTER_LEN     = 8
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       keyClock,
    input  logic       keyData,
    output logic       keyClockDrive,
    output logic       keyDataDrive,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int unsigned InhW  = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);

    // The clock is held low for INHIBIT_CYCLES in total, the last of which is the
    // START cycle where the start bit is placed on the data line.
    localparam logic [InhW-1:0]  InhLast  = InhW'(INHIBIT_CYCLES - 2);
    localparam logic [ToW-1:0]   ToLast   = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StStart,
        StShift,
        StAck,
        StWaitIdle,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= keyClock;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= keyData;
            dat_sync_q <= dat_meta_q;
        end
    end

    logic             filt_q, filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             clk_fall;

    // Count consecutive samples that disagree with the filtered level; any
    // agreeing sample restarts the count, so short glitches never get through.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FiltLast) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // High for exactly the cycle in which the filtered clock drops.
    assign clk_fall = filt_q & ~filt_d;

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      data_q, data_d;
    logic            parity_q, parity_d;
    logic            ack_bad_q, ack_bad_d;
    logic            ckd_q, ckd_d;
    logic            kdd_q, kdd_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic            ack_err_q, ack_err_d;
    logic            to_err_q, to_err_d;

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        parity_d  = parity_q;
        ack_bad_d = ack_bad_q;
        ckd_d     = ckd_q;
        kdd_d     = kdd_q;
        busy_d    = busy_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        to_err_d  = to_err_q;

        unique case (state_q)
            StIdle: begin
                if (tx_valid && ready_q) begin
                    data_d    = tx_data;
                    parity_d  = ~^tx_data;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                    ckd_d     = 1'b1;
                    ack_err_d = 1'b0;
                    to_err_d  = 1'b0;
                    inh_cnt_d = '0;
                    state_d   = StInhibit;
                end
            end

            StInhibit: begin
                if (inh_cnt_q == InhLast) begin
                    kdd_d   = 1'b1;
                    state_d = StStart;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end

            StStart: begin
                ckd_d     = 1'b0;
                to_cnt_d  = '0;
                bit_idx_d = '0;
                state_d   = StShift;
            end

            StShift, StAck: begin
                // Counter stops at TIMEOUT_CYCLES: it is only advanced here and the
                // abort leaves these states on the cycle it gets there.
                to_cnt_d = to_cnt_q + 1'b1;
                if (to_cnt_q == ToLast) begin
                    ckd_d     = 1'b0;
                    kdd_d     = 1'b0;
                    done_d    = 1'b1;
                    to_err_d  = 1'b1;
                    ack_err_d = 1'b0;
                    state_d   = StDone;
                end else if (clk_fall) begin
                    if (state_q == StAck) begin
                        ack_bad_d = dat_sync_q;
                        state_d   = StWaitIdle;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        if (bit_idx_q < 4'd8) begin
                            kdd_d = ~data_q[bit_idx_q[2:0]];
                        end else if (bit_idx_q == 4'd8) begin
                            kdd_d = ~parity_q;
                        end else begin
                            kdd_d   = 1'b0;
                            state_d = StAck;
                        end
                    end
                end
            end

            StWaitIdle: begin
                if (filt_q && dat_sync_q) begin
                    done_d    = 1'b1;
                    ack_err_d = ack_bad_q;
                    to_err_d  = 1'b0;
                    state_d   = StDone;
                end
            end

            StDone: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = StIdle;
            end

            default: begin
                ckd_d   = 1'b0;
                kdd_d   = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            ack_bad_q <= 1'b0;
            ckd_q     <= 1'b0;
            kdd_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            ack_bad_q <= ack_bad_d;
            ckd_q     <= ckd_d;
            kdd_q     <= kdd_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            to_err_q  <= to_err_d;
        end
    end

    assign tx_ready      = ready_q;
    assign keyClockDrive = ckd_q;
    assign keyDataDrive  = kdd_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign ack_err       = ack_err_q;
    assign timeout_err   = to_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural PS/2 device.
// Stimulus pushes the expected outcome of each transaction into a queue; a monitor
// pops and compares whenever the DUT pulses done.

module tb_ps2_host_tx;

    localparam int unsigned INH  = 60;
    localparam int unsigned TO   = 2000;
    localparam int unsigned FILT = 8;
    localparam int unsigned HALF = 40;

    logic       sysclk = 1'b0;
    logic       rst_n  = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_ready, keyClock, keyData, keyClockDrive, keyDataDrive;
    logic       busy, done, ack_err, timeout_err;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;

    // Open-drain lines with pull-ups.
    assign keyClock = ~(keyClockDrive | dev_clk_low);
    assign keyData  = ~(keyDataDrive | dev_dat_low);

    always #5 sysclk = ~sysclk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (FILT)
    ) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .keyClock     (keyClock),
        .keyData      (keyData),
        .keyClockDrive(keyClockDrive),
        .keyDataDrive (keyDataDrive),
        .busy         (busy),
        .done         (done),
        .ack_err      (ack_err),
        .timeout_err  (timeout_err)
    );

    typedef struct {
        logic [10:0] frame;
        bit          chk_frame;
        bit          ack_err;
        bit          to_err;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] obs_q[$];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int rel_cyc  = 0;
    int hi_cnt   = 0;
    bit prev_ckd = 1'b0;
    bit data_in_inh    = 1'b0;
    bit chk_ready_next = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            if (b[i]) ones++;
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Monitor: inhibit timing at every clock release, scoreboard pop at every done.
    always @(negedge sysclk) begin
        cyc++;
        if (!rst_n) begin
            prev_ckd       = 1'b0;
            hi_cnt         = 0;
            data_in_inh    = 1'b0;
            chk_ready_next = 1'b0;
        end else begin
            if (chk_ready_next) begin
                check("ready_after_done", 32'(tx_ready), 32'd1);
                check("busy_after_done", 32'(busy), 32'd0);
                chk_ready_next = 1'b0;
            end
            if (keyClockDrive === 1'b1) begin
                hi_cnt++;
                if (keyDataDrive === 1'b1) data_in_inh = 1'b1;
            end else if (prev_ckd) begin
                rel_cyc = cyc;
                check("inhibit_len", 32'(hi_cnt), 32'(INH));
                check("start_before_release", 32'(data_in_inh), 32'd1);
                hi_cnt      = 0;
                data_in_inh = 1'b0;
            end
            prev_ckd = (keyClockDrive === 1'b1);

            if (done === 1'b1) begin
                done_cnt++;
                chk_ready_next = 1'b1;
                check("done_clk_drive", 32'(keyClockDrive), 32'd0);
                check("done_dat_drive", 32'(keyDataDrive), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_err", 32'(ack_err), 32'(e.ack_err));
                    check("timeout_err", 32'(timeout_err), 32'(e.to_err));
                    if (e.to_err) check("timeout_latency", 32'(cyc - rel_cyc), 32'(TO));
                    if (e.chk_frame) begin
                        if (obs_q.size() == 0) check("frame_missing", 32'(obs_q.size()), 32'd1);
                        else check("frame", 32'(obs_q.pop_front()), 32'(e.frame));
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int w;
        w = 0;
        while (tx_ready !== 1'b1 && w < 10000) begin
            @(posedge sysclk);
            w++;
        end
        check("ready_before_send", 32'(tx_ready), 32'd1);
        @(negedge sysclk);
        tx_valid = 1'b1;
        tx_data  = b;
        @(posedge sysclk);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        check("accept_ready_low", 32'(tx_ready), 32'd0);
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_clr_ack_err", 32'(ack_err), 32'd0);
        check("accept_clr_to_err", 32'(timeout_err), 32'd0);
    endtask

    // Device: waits for request-to-send, clocks nclk bits, samples on clock high.
    task automatic device(input int nclk, input bit do_ack, input bit glitch);
        logic [10:0] f;
        int w;
        f = '0;
        w = 0;
        while (!(keyClock === 1'b1 && keyData === 1'b0) && w < 5000) begin
            @(posedge sysclk);
            w++;
        end
        if (w >= 5000) begin
            check("device_request_seen", 32'(w), 32'd0);
        end else begin
            repeat (20) @(posedge sysclk);
            f[0] = keyData;
            for (int k = 1; k <= nclk; k++) begin
                dev_clk_low = 1'b1;
                repeat (HALF) @(posedge sysclk);
                dev_clk_low = 1'b0;
                if (glitch && k == 5) begin
                    repeat (10) @(posedge sysclk);
                    dev_clk_low = 1'b1;
                    repeat (3) @(posedge sysclk);
                    dev_clk_low = 1'b0;
                    repeat (HALF - 13) @(posedge sysclk);
                end else begin
                    repeat (HALF) @(posedge sysclk);
                end
                f[k] = keyData;
            end
            if (nclk == 10) begin
                obs_q.push_back(f);
                dev_dat_low = do_ack;
                dev_clk_low = 1'b1;
                repeat (HALF) @(posedge sysclk);
                dev_clk_low = 1'b0;
                repeat (HALF) @(posedge sysclk);
                dev_dat_low = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input int start, input int limit);
        int w;
        w = 0;
        while (done_cnt == start && w < limit) begin
            @(posedge sysclk);
            w++;
        end
        check("done_seen", 32'(done_cnt - start), 32'd1);
        repeat (3) @(posedge sysclk);
    endtask

    task automatic txn(input logic [7:0] b, input bit do_ack);
        int dc;
        dc = done_cnt;
        exp_q.push_back('{frame: frame_of(b), chk_frame: 1'b1, ack_err: !do_ack, to_err: 1'b0});
        send(b);
        device(10, do_ack, 1'b0);
        wait_done(dc, 3000);
    endtask

    initial begin
        int dc;
        logic [7:0] rb;
        bit ra;

        #2 rst_n = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_clk_drive", 32'(keyClockDrive), 32'd0);
        check("rst_dat_drive", 32'(keyDataDrive), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_to_err", 32'(timeout_err), 32'd0);
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (20) @(posedge sysclk);

        txn(8'hED, 1'b1);
        txn(8'hF4, 1'b1);
        txn(8'h00, 1'b1);

        // No acknowledge; error flag must persist until the next accept.
        txn(8'hA5, 1'b0);
        repeat (10) @(posedge sysclk);
        #1;
        check("ack_err_hold", 32'(ack_err), 32'd1);
        check("noack_dat_drive", 32'(keyDataDrive), 32'd0);

        // Dead device.
        dc = done_cnt;
        exp_q.push_back('{frame: '0, chk_frame: 1'b0, ack_err: 1'b0, to_err: 1'b1});
        send(8'h3C);
        wait_done(dc, int'(INH + TO + 200));
        #1;
        check("timeout_dat_release", 32'(keyDataDrive), 32'd0);

        // Request while busy is ignored.
        dc = done_cnt;
        exp_q.push_back('{frame: frame_of(8'hED), chk_frame: 1'b1, ack_err: 1'b0, to_err: 1'b0});
        send(8'hED);
        repeat (5) @(posedge sysclk);
        @(negedge sysclk);
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        @(posedge sysclk);
        #1;
        tx_valid = 1'b0;
        device(10, 1'b1, 1'b0);
        wait_done(dc, 3000);
        repeat (INH + 50) @(posedge sysclk);
        check("single_done", 32'(done_cnt - dc), 32'd1);
        check("no_restart_after_busy_req", 32'(keyClockDrive), 32'd0);

        // Reset mid-SHIFT after bit 3.
        send(8'h5A);
        device(4, 1'b0, 1'b0);
        dc = done_cnt;
        @(posedge sysclk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_clk_drive", 32'(keyClockDrive), 32'd0);
        check("midrst_dat_drive", 32'(keyDataDrive), 32'd0);
        check("midrst_tx_ready", 32'(tx_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge sysclk);
        @(negedge sysclk);
        rst_n = 1'b1;
        repeat (20) @(posedge sysclk);
        check("midrst_no_done", 32'(done_cnt), 32'(dc));
        txn(8'hFF, 1'b1);

        // Short low glitch on the clock during SHIFT.
        dc = done_cnt;
        exp_q.push_back('{frame: frame_of(8'h96), chk_frame: 1'b1, ack_err: 1'b0, to_err: 1'b0});
        send(8'h96);
        device(10, 1'b1, 1'b1);
        wait_done(dc, 3000);

        for (int n = 0; n < 5; n++) begin
            rb = 8'($urandom);
            ra = 1'($urandom_range(0, 1));
            txn(rb, ra);
        end

        repeat (10) @(posedge sysclk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
